// File: rtl/ddr_read_arbiter.sv
// ddr_read_arbiter
// Shares the DDR controller's single read port between a high-priority
// display requester (port 0) and a user/debug requester (port 1). One read
// is sequenced at a time: IDLE -> ISSUE -> WAIT -> DONE. Port 1 is forced
// through after STARVE_LIMIT back-to-back port-0 wins. A read that sees no
// data within TIMEOUT wait cycles completes with an error. Every output is
// registered, so no input reaches an output combinationally.
module ddr_read_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              valid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              valid1,
    output logic [DATA_W-1:0] readData,
    output logic              readErr,
    output logic              ddrReadRequest,
    output logic [ADDR_W-1:0] ddrReadAddress,
    input  logic              ddrIdle,
    input  logic              ddrReadValid,
    input  logic [DATA_W-1:0] ddrReadData,
    output logic              timeoutErr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_MAX     = 8'(TIMEOUT);

    logic [1:0] state;
    logic       grant;        // owner of the in-flight read: 0 = port 0, 1 = port 1
    logic [3:0] starve_cnt;   // consecutive port-0 wins while port 1 was waiting
    logic [7:0] to_cnt;       // cycles spent in WAIT without data

    logic start;              // a read is launched from IDLE this cycle
    logic pick1;              // port 1 wins the launch
    logic data_hit;           // data returned during WAIT
    logic to_hit;             // wait budget exhausted without data
    logic complete;           // the in-flight read finishes this cycle

    // Arbitration and completion decisions for the current cycle
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        start    = 1'b0;
        pick1    = 1'b0;
        data_hit = 1'b0;
        to_hit   = 1'b0;
        if (state == ST_IDLE && (req0 || req1) && ddrIdle) begin
            start = 1'b1;
            pick1 = req1 && (!req0 || starve_cnt == STARVE_MAX);
        end
        if (state == ST_WAIT) begin
            // Data arriving on the last permitted cycle still wins over the timeout.
            data_hit = ddrReadValid;
            to_hit   = !ddrReadValid && (to_cnt == TO_MAX);
        end
        complete = data_hit || to_hit;
    end

    // Sequencer: one read at a time through IDLE, ISSUE, WAIT, DONE
    always_ff @(posedge clk) begin
        // NOTE: registered state is written with non-blocking assignments so
        // every block samples the pre-edge values of its neighbours.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_ISSUE;
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT:  if (complete) state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Launch: latch the winner, its address, and strobe the controller once
    always_ff @(posedge clk) begin
        if (rst) begin
            grant          <= 1'b0;
            ddrReadRequest <= 1'b0;
            ddrReadAddress <= '0;
        end else begin
            ddrReadRequest <= start;
            if (start) begin
                grant          <= pick1;
                ddrReadAddress <= pick1 ? addr1 : addr0;
            end
        end
    end

    // Starvation counter: counts port-0 wins that left port 1 waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (start) begin
            if (pick1 || !req1) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Completion timer: cleared on the strobe, advances each empty WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT && !complete) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    // Completion: capture data or error, then pulse the owner's valid in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            valid0     <= 1'b0;
            valid1     <= 1'b0;
            readData   <= '0;
            readErr    <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            valid0 <= complete && !grant;
            valid1 <= complete && grant;
            if (data_hit) begin
                readData <= ddrReadData;
                readErr  <= 1'b0;
            end else if (to_hit) begin
                readData   <= '0;
                readErr    <= 1'b1;
                timeoutErr <= 1'b1;
            end
        end
    end

endmodule
